// File: rtl/masked_xor_pipe.sv
// masked_xor_pipe: two-stage registered share-wise XOR of (D+1)-share masked operands.
// Stage 1 holds A^B per share, stage 2 drives port_c and optionally re-randomises
// the shares with a ring refresh.
// Optional feature macro: MASKED_XOR_REFRESH_EN (adds port_r and the ring refresh).
module masked_xor_pipe #(
    parameter int D = 1,
    parameter int K = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [(D+1)*K-1:0]   port_a,
    input  logic [(D+1)*K-1:0]   port_b,
    input  logic                 in_valid,
    output logic                 in_ready,
`ifdef MASKED_XOR_REFRESH_EN
    input  logic [(D+1)*K-1:0]   port_r,
`endif
    output logic [(D+1)*K-1:0]   port_c,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0]          xfer_cnt
);

    localparam int N = D + 1;
    localparam int W = N * K;

    logic         v1;
    logic         v2;
    logic [W-1:0] s1_c;
    logic [W-1:0] s2_c;
    logic [W-1:0] s2_next;
    logic         in_xfer;
    logic         s2_load;
    logic         out_xfer;

    assign s2_load   = v1 & (~v2 | out_ready);
    assign in_ready  = ~v1 | ~v2 | out_ready;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = v2 & out_ready;
    assign out_valid = v2;
    assign port_c    = s2_c;

`ifdef MASKED_XOR_REFRESH_EN
    // Ring refresh: each r[i] enters two neighbouring shares, so the unmasked value
    // is unchanged. With a single share r[0]^r[0] cancels and S2 equals s1_c.
    always_comb begin
        s2_next = s1_c;
        for (int i = 0; i < N; i++) begin
            s2_next[i*K +: K] = s1_c[i*K +: K] ^ port_r[i*K +: K]
                              ^ port_r[((i + 1) % N)*K +: K];
        end
    end
`else
    assign s2_next = s1_c;
`endif

    // Stage 1: share-wise XOR captured on input transfer; shares never mix.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            s1_c <= '0;
        end else begin
            if (in_xfer) begin
                s1_c <= port_a ^ port_b;
            end
            v1 <= in_xfer | (v1 & ~s2_load);
        end
    end

    // Stage 2: output register, held stable while back-pressured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            s2_c <= '0;
        end else begin
            if (s2_load) begin
                s2_c <= s2_next;
            end
            v2 <= s2_load | (v2 & ~out_ready);
        end
    end

    // Completed output transfers, wrapping at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt <= 16'd0;
        end else if (out_xfer) begin
            xfer_cnt <= xfer_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_masked_xor_pipe.sv
// Bench for masked_xor_pipe: directed vectors, back-pressure, reset, random streams
// and counter wrap, checked against a queue-based reference model.
module tb_masked_xor_pipe;

`ifdef MASKED_XOR_REFRESH_EN
    localparam int D = 2;
    localparam int K = 4;
`else
    localparam int D = 1;
    localparam int K = 2;
`endif
    localparam int N = D + 1;
    localparam int W = N * K;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] port_a;
    logic [W-1:0] port_b;
    logic         in_valid;
    logic         in_ready;
`ifdef MASKED_XOR_REFRESH_EN
    logic [W-1:0] port_r;
`endif
    logic [W-1:0] port_c;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  xfer_cnt;

    masked_xor_pipe #(.D(D), .K(K)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .port_a    (port_a),
        .port_b    (port_b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef MASKED_XOR_REFRESH_EN
        .port_r    (port_r),
`endif
        .port_c    (port_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .xfer_cnt  (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] c;
        logic [K-1:0] u;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
    } vec_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_acc    = 0;
    int   n_out    = 0;
    int   n_xfer   = 0;

    function automatic logic [K-1:0] unmask(input logic [W-1:0] v);
        logic [K-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r = r ^ v[i*K +: K];
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Called at a negedge after inputs are set; returns at the following negedge.
    task automatic step();
        exp_t e;
        #1;
        if (in_valid && in_ready) begin
            e.c = port_a ^ port_b;
            e.u = unmask(port_a) ^ unmask(port_b);
            exp_q.push_back(e);
            n_acc++;
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: actual=%0h required=none", port_c);
            end else begin
                e = exp_q.pop_front();
`ifndef MASKED_XOR_REFRESH_EN
                check("result_shares", 32'(port_c), 32'(e.c));
`endif
                check("result_unmasked", 32'(unmask(port_c)), 32'(e.u));
            end
            n_out++;
            n_xfer++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int acc0;
        int out0;
        int k;
        logic [W-1:0] held;
        logic         have_held;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        port_a    = '0;
        port_b    = '0;
`ifdef MASKED_XOR_REFRESH_EN
        port_r    = '0;
`endif

        // Reset with random activity on the inputs.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            port_a   = W'($urandom);
            port_b   = W'($urandom);
            in_valid = 1'b1;
        end
        #1;
        check("rst_port_c", 32'(port_c), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_xfer_cnt", 32'(xfer_cnt), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step();
        check("post_rst_empty", 32'(out_valid), 32'h0);

`ifdef MASKED_XOR_REFRESH_EN
        port_a   = 12'h321;
        port_b   = 12'h000;
        port_r   = 12'hF5A;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("refresh_lat1", 32'(out_valid), 32'h0);
        step();
        check("refresh_valid", 32'(out_valid), 32'h1);
        check("refresh_shares", 32'(port_c), 32'h68E);
        check("refresh_unmasked", 32'(unmask(port_c)), 32'h0);
        step();
`else
        begin
            vec_t tbl[5];
            tbl[0] = '{a: 4'b1001, b: 4'b1100, c: 4'b0101};
            tbl[1] = '{a: 4'hF,    b: 4'h0,    c: 4'hF};
            tbl[2] = '{a: 4'h5,    b: 4'h5,    c: 4'h0};
            tbl[3] = '{a: 4'h3,    b: 4'hA,    c: 4'h9};
            tbl[4] = '{a: 4'hC,    b: 4'h6,    c: 4'hA};
            for (int i = 0; i < 5; i++) begin
                port_a   = tbl[i].a;
                port_b   = tbl[i].b;
                in_valid = 1'b1;
                step();
                in_valid = 1'b0;
                check("vec_lat1_valid", 32'(out_valid), 32'h0);
                step();
                check("vec_valid", 32'(out_valid), 32'h1);
                check("vec_port_c", 32'(port_c), 32'(tbl[i].c));
                step();
            end
        end
`endif

        // Back-pressure: 4 ops with out_ready low, then drain.
        out_ready = 1'b0;
        acc0      = n_acc;
        out0      = n_out;
        k         = 0;
        have_held = 1'b0;
        held      = '0;
        for (int c = 0; c < 6; c++) begin
            if (k < 4) begin
                if (n_acc == acc0 + k) begin
                    port_a = W'($urandom);
                    port_b = W'($urandom);
                end
                in_valid = 1'b1;
            end
            step();
            k = n_acc - acc0;
            if (out_valid) begin
                if (have_held) check("stall_hold", 32'(port_c), 32'(held));
                held      = port_c;
                have_held = 1'b1;
            end
        end
        check("bp_accepted", 32'(n_acc - acc0), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'h0);
        check("bp_out_valid", 32'(out_valid), 32'h1);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && (k < 4 || exp_q.size() != 0); c++) begin
            if (k < 4) begin
                if (n_acc == acc0 + k) begin
                    port_a = W'($urandom);
                    port_b = W'($urandom);
                end
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            step();
            k = n_acc - acc0;
        end
        in_valid = 1'b0;
        check("bp_drained", 32'(n_out - out0), 32'd4);
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset while the pipeline is full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'h0);
        check("midrst_port_c", 32'(port_c), 32'h0);
        check("midrst_xfer_cnt", 32'(xfer_cnt), 32'h0);
        exp_q.delete();
        n_xfer = 0;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        port_a    = W'($urandom);
        port_b    = W'($urandom);
        step();
        in_valid = 1'b0;
        step();
        check("midrst_first_valid", 32'(out_valid), 32'h1);
        step();
        check("midrst_first_cnt", 32'(xfer_cnt), 32'd1);

        // Full-rate random stream.
        acc0 = n_acc;
        out0 = n_out;
        for (int i = 0; i < 1000; i++) begin
            port_a   = W'($urandom);
            port_b   = W'($urandom);
`ifdef MASKED_XOR_REFRESH_EN
            port_r   = W'($urandom);
`endif
            in_valid = 1'b1;
            step();
        end
        check("stream_accepted", 32'(n_acc - acc0), 32'd1000);
        check("stream_rate", 32'(n_out - out0), 32'd998);
        in_valid = 1'b0;
        step();
        step();
        check("stream_drained", 32'(n_out - out0), 32'd1000);
        check("stream_xfer_cnt", 32'(xfer_cnt), 32'(n_xfer[15:0]));

        // Random valid/ready traffic.
        for (int i = 0; i < 500; i++) begin
            port_a    = W'($urandom);
            port_b    = W'($urandom);
`ifdef MASKED_XOR_REFRESH_EN
            port_r    = W'($urandom);
`endif
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        check("random_queue_empty", 32'(exp_q.size()), 32'd0);
        check("random_xfer_cnt", 32'(xfer_cnt), 32'(n_xfer[15:0]));

        // Counter wrap.
        for (int i = 0; i < 70000 && n_xfer < 65535; i++) begin
            port_a   = W'($urandom);
            port_b   = W'($urandom);
            in_valid = 1'b1;
            step();
        end
        check("wrap_preload", 32'(xfer_cnt), 32'hFFFF);
        step();
        check("wrap_zero", 32'(xfer_cnt), 32'h0);
        in_valid = 1'b0;
        step();
        step();
        check("wrap_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
